pong_game_sequencer: RTL
========================

# pong_game_sequencer

Game-flow controller for Pong. Sequences attract, serve delay, rally, miss/score pause and game-over, and owns the score registers. It replaces the free-running analogue-style one-shot timers for the serve and miss delays with a single shared down-counter. It sits between the coin/start input, the ball-miss detectors and the score display, video and sound logic.

## Interface

Parameters:

- CLK_FREQ, 0: clock frequency in Hz.
- SERVE_MS, 0: serve delay in ms. Ball is held before release.
- MISS_MS, 0: miss pause in ms. Miss sound plays and the ball is held.
- WIN_SCORE, 11: score that ends the game. Must be ≤ 2^SCORE_W − 1.
- SCORE_W, 4: width of each score register.

Ports:

- _clk, in, 1: system clock. All state updates on the falling edge.
- reset, in, 1: synchronous, active-high reset, sampled on the falling edge of _clk.
- coin, in, 1: start request, level sampled each edge.
- miss_left, in, 1: ball exited past the left paddle. Right player scores.
- miss_right, in, 1: ball exited past the right paddle. Left player scores.
- attract, out, 1: attract/idle mode active.
- serve_hold, out, 1: ball held in the serve position. Ball motion disabled.
- miss_snd, out, 1: miss-sound enable.
- score_tick, out, 1: one-cycle pulse on each score increment.
- score_left, out, SCORE_W: left player score.
- score_right, out, SCORE_W: right player score.
- game_over, out, 1: a player reached WIN_SCORE.

## Operation

Tick counts:

- SERVE_TICKS = (CLK_FREQ/1000)*SERVE_MS.
- MISS_TICKS = (CLK_FREQ/1000)*MISS_MS.
- Both use 32-bit integer arithmetic. A computed value of 0 is forced to 1.

There is a single 32-bit down-counter `cnt`, shared by the SERVE and MISS states.

State machine:

- **ATTRACT**
  - Outputs: attract=1, serve_hold=1.
  - coin=1: scores←0, cnt←SERVE_TICKS, go to SERVE.
- **SERVE**
  - Outputs: serve_hold=1.
  - Each edge decrements cnt. The edge where cnt goes 1→0 goes to PLAY.
  - coin, miss_left and miss_right are ignored.
- **PLAY**
  - Outputs: serve_hold=0.
  - miss_left=1: score_right+1, score_tick=1, cnt←MISS_TICKS, go to MISS.
  - Otherwise miss_right=1: score_left+1, same actions, go to MISS.
  - If both are asserted on the same edge, miss_left wins and miss_right is dropped.
  - coin is ignored.
- **MISS**
  - Outputs: serve_hold=1, miss_snd=1.
  - Each edge decrements cnt.
  - On the 1→0 edge: if either score == WIN_SCORE, go to OVER. Otherwise cnt←SERVE_TICKS and go to SERVE.
  - Miss inputs and coin are ignored.
- **OVER**
  - Outputs: attract=1, game_over=1, serve_hold=1. Scores are held for display.
  - coin=1: scores←0, game_over←0, cnt←SERVE_TICKS, go to SERVE.

Score rules:

- Increments saturate at WIN_SCORE and never wrap.
- Scores change only in PLAY, or on a coin-triggered clear.

Reset, asserted in any state:

- Next edge state is ATTRACT and cnt=0.
- Scores are 0.
- Outputs: attract=1, serve_hold=1, miss_snd=0, score_tick=0, game_over=0.
- Reset has priority over every other input.

## Timing

- All outputs are registered. Each changes on the same falling edge as the state transition that causes it.
- Coin to serve:
  - coin sampled high in ATTRACT or OVER at edge N: state is SERVE at edge N.
  - attract drops at edge N. Scores read 0 from edge N.
- Serve duration:
  - serve_hold stays high for exactly SERVE_TICKS cycles after entering SERVE.
  - serve_hold falls at edge N+SERVE_TICKS.
- Miss handling, for a miss at edge M in PLAY:
  - At edge M: score updated, score_tick=1, serve_hold=1, miss_snd=1.
  - At edge M+1: score_tick=0.
  - At edge M+MISS_TICKS: miss_snd=0.
- After the miss pause:
  - Next serve: serve_hold falls at edge M+MISS_TICKS+SERVE_TICKS.
  - Game over: game_over rises at edge M+MISS_TICKS.
- Held inputs:
  - A coin held high through a whole game restarts it immediately on entering OVER, one edge later.
  - A miss input held high across the MISS→SERVE→PLAY sequence scores again on the first PLAY edge. Upstream must pulse the miss inputs.

## Test plan

Bench parameters: CLK_FREQ=4000, SERVE_MS=2 (8 ticks), MISS_MS=1 (4 ticks), WIN_SCORE=3, SCORE_W=4.

- **Reset:** reset high for 2 edges. Expect attract=1, serve_hold=1, both scores 0, game_over=0, miss_snd=0.
- **Coin and serve:** coin pulse at edge 10. Expect attract 0 at edge 10 and serve_hold 1→0 at edge 18, exactly 8 cycles later.
- **Single miss:** miss_right pulse in PLAY at edge 30. Expect score_left=1, score_tick high only at edge 30, miss_snd high for edges 30–33, and serve_hold falling again at edge 42.
- **Simultaneous misses:** miss_left and miss_right together in PLAY. Expect score_right+1, score_left unchanged, and a single score_tick.
- **Game over:** three miss_left pulses. Expect score_right=3. game_over=1 and attract=1 appear 4 edges after the third miss, with scores held. Then coin: scores 0, game_over 0, state SERVE.
- **Reset mid-operation and ignored inputs:**
  - reset in MISS with cnt=2: next edge is ATTRACT, scores 0, miss_snd 0.
  - coin during PLAY: no state change.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: attract, serve delay, rally, miss pause and game-over,
// with score ownership and one shared down-counter for the serve and miss delays.
module pong_game_sequencer #(
    parameter int unsigned CLK_FREQ  = 0,
    parameter int unsigned SERVE_MS  = 0,
    parameter int unsigned MISS_MS   = 0,
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned SCORE_W   = 4
) (
    input  logic               _clk,
    input  logic               reset,
    input  logic               coin,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               attract,
    output logic               serve_hold,
    output logic               miss_snd,
    output logic               score_tick,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over
);

    localparam logic [31:0] SERVE_RAW   = (CLK_FREQ / 32'd1000) * SERVE_MS;
    localparam logic [31:0] MISS_RAW    = (CLK_FREQ / 32'd1000) * MISS_MS;
    localparam logic [31:0] SERVE_TICKS = (SERVE_RAW == '0) ? 32'd1 : SERVE_RAW;
    localparam logic [31:0] MISS_TICKS  = (MISS_RAW == '0) ? 32'd1 : MISS_RAW;
    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_ATTRACT,
        ST_SERVE,
        ST_PLAY,
        ST_MISS,
        ST_OVER
    } state_t;

    state_t             state, state_n;
    logic [31:0]        cnt, cnt_n;
    logic [SCORE_W-1:0] left_n, right_n;
    logic               tick_n;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + 1'b1;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        left_n  = score_left;
        right_n = score_right;
        tick_n  = 1'b0;
        case (state)
            ST_ATTRACT, ST_OVER: begin
                if (coin) begin
                    left_n  = '0;
                    right_n = '0;
                    cnt_n   = SERVE_TICKS;
                    state_n = ST_SERVE;
                end
            end
            ST_SERVE: begin
                cnt_n = (cnt == '0) ? '0 : cnt - 32'd1;
                if (cnt <= 32'd1) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                // miss_left wins when both detectors fire on the same edge
                if (miss_left) begin
                    right_n = sat_inc(score_right);
                    tick_n  = 1'b1;
                    cnt_n   = MISS_TICKS;
                    state_n = ST_MISS;
                end else if (miss_right) begin
                    left_n  = sat_inc(score_left);
                    tick_n  = 1'b1;
                    cnt_n   = MISS_TICKS;
                    state_n = ST_MISS;
                end
            end
            ST_MISS: begin
                cnt_n = (cnt == '0) ? '0 : cnt - 32'd1;
                if (cnt <= 32'd1) begin
                    if (score_left == WIN || score_right == WIN) begin
                        state_n = ST_OVER;
                    end else begin
                        cnt_n   = SERVE_TICKS;
                        state_n = ST_SERVE;
                    end
                end
            end
            default: state_n = ST_ATTRACT;
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(negedge _clk) begin
        if (reset) begin
            state       <= ST_ATTRACT;
            cnt         <= '0;
            score_left  <= '0;
            score_right <= '0;
            attract     <= 1'b1;
            serve_hold  <= 1'b1;
            miss_snd    <= 1'b0;
            score_tick  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            score_left  <= left_n;
            score_right <= right_n;
            attract     <= (state_n == ST_ATTRACT) || (state_n == ST_OVER);
            serve_hold  <= (state_n != ST_PLAY);
            miss_snd    <= (state_n == ST_MISS);
            score_tick  <= tick_n;
            game_over   <= (state_n == ST_OVER);
        end
    end

endmodule
